// File: rtl/tri_pixel_walker.sv
// ---------------------------------------------------------------------------------------------
// tri_pixel_walker
//
// Upstream initiator for bayesian_coord. Takes one triangle as three unsigned integer
// pixel-space vertices, computes its bounding box and walks every pixel of that box in raster
// order. Each pixel is presented together with the triangle's vertices, all converted to IEEE
// half-float, over an nd/rfd handshake.
//
// Optional feature (compile-time macro BBOX_CLIP_EN):
//   defined   : the box is clamped to SCREEN_W x SCREEN_H. A triangle whose box starts fully
//               off-screen issues no pixels but still produces tri_done.
//   undefined : no clamping; the walk covers the full box.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   tri_nd / tri_rfd     triangle valid / walker ready (ready only while idle)
//   tv{1,2,3}_{x,y}      integer vertex coordinates, sampled on the accept edge only
//   pix_nd / pix_rfd     pixel valid / downstream ready
//   v{1,2,3}_{x,y}       half-float vertices, held for the whole triangle
//   p_x, p_y             half-float pixel position
//   pix_last             marks the final pixel of the triangle
//   tri_done             one-cycle pulse after the last pixel is accepted
// ---------------------------------------------------------------------------------------------
module tri_pixel_walker #(
   parameter int unsigned COORD_W  = 11,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480
) (
   input  logic               clk,
   input  logic               rst,
   // triangle input
   input  logic               tri_nd,
   output logic               tri_rfd,
   input  logic [COORD_W-1:0] tv1_x,
   input  logic [COORD_W-1:0] tv1_y,
   input  logic [COORD_W-1:0] tv2_x,
   input  logic [COORD_W-1:0] tv2_y,
   input  logic [COORD_W-1:0] tv3_x,
   input  logic [COORD_W-1:0] tv3_y,
   // pixel output
   output logic               pix_nd,
   input  logic               pix_rfd,
   output logic [15:0]        v1_x,
   output logic [15:0]        v1_y,
   output logic [15:0]        v2_x,
   output logic [15:0]        v2_y,
   output logic [15:0]        v3_x,
   output logic [15:0]        v3_y,
   output logic [15:0]        p_x,
   output logic [15:0]        p_y,
   output logic               pix_last,
   output logic               tri_done
);

   // ------------------------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------------------------
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBbox = 2'd1;
   localparam logic [1:0] StWalk = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

`ifdef BBOX_CLIP_EN
   localparam bit ClipEn = 1'b1;
`else
   localparam bit ClipEn = 1'b0;
`endif

   // Last visible column/row; only consulted when clipping is enabled.
   localparam logic [COORD_W-1:0] XLim = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] YLim = COORD_W'(SCREEN_H - 1);

   // ------------------------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------------------------
   // Exact unsigned integer to half-float; valid because COORD_W <= 11 keeps every value within
   // the 11 significant bits of a half.
   function automatic logic [15:0] int2half(input logic [COORD_W-1:0] n);
      logic [10:0] nw;
      logic [3:0]  e;
      logic [4:0]  ex;
      logic [9:0]  mant;
      nw = 11'(n);
      e  = 4'd0;
      for (int i = 0; i < 11; i++) begin
         if (nw[i]) e = 4'(i);
      end
      ex   = 5'(e) + 5'd15;
      // Normalise so the leading one lands on bit 10; it is implicit and dropped.
      mant = 10'(nw << (4'd10 - e));
      if (nw == 11'd0) begin
         int2half = 16'h0000;
      end else begin
         int2half = {1'b0, ex, mant};
      end
   endfunction

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m    = (a < b) ? a : b;
      min3 = (c < m) ? c : m;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m    = (a > b) ? a : b;
      max3 = (c > m) ? c : m;
   endfunction

   // ------------------------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------------------------
   logic [1:0]         state_q, state_d;
   logic [COORD_W-1:0] in_x_q [3];
   logic [COORD_W-1:0] in_x_d [3];
   logic [COORD_W-1:0] in_y_q [3];
   logic [COORD_W-1:0] in_y_d [3];
   logic [15:0]        vh_x_q [3];
   logic [15:0]        vh_x_d [3];
   logic [15:0]        vh_y_q [3];
   logic [15:0]        vh_y_d [3];
   logic [COORD_W-1:0] xmin_q, xmin_d;
   logic [COORD_W-1:0] xmax_q, xmax_d;
   logic [COORD_W-1:0] ymax_q, ymax_d;
   logic [COORD_W-1:0] cx_q, cx_d;
   logic [COORD_W-1:0] cy_q, cy_d;
   logic [15:0]        p_x_q, p_x_d;
   logic [15:0]        p_y_q, p_y_d;
   logic               pix_nd_q, pix_nd_d;
   logic               pix_last_q, pix_last_d;
   logic               tri_done_q, tri_done_d;

   // ------------------------------------------------------------------------------------------
   // Bounding box of the registered vertices
   // ------------------------------------------------------------------------------------------
   logic [COORD_W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
   logic [COORD_W-1:0] xmax_clip, ymax_clip;
   logic               off_screen;

   always_comb begin
      xmin_c     = min3(in_x_q[0], in_x_q[1], in_x_q[2]);
      xmax_c     = max3(in_x_q[0], in_x_q[1], in_x_q[2]);
      ymin_c     = min3(in_y_q[0], in_y_q[1], in_y_q[2]);
      ymax_c     = max3(in_y_q[0], in_y_q[1], in_y_q[2]);
      xmax_clip  = (ClipEn && (xmax_c > XLim)) ? XLim : xmax_c;
      ymax_clip  = (ClipEn && (ymax_c > YLim)) ? YLim : ymax_c;
      off_screen = ClipEn && ((xmin_c > XLim) || (ymin_c > YLim));
   end

   // ------------------------------------------------------------------------------------------
   // Raster stepping: position of the pixel that follows the current one
   // ------------------------------------------------------------------------------------------
   logic               at_xmax;
   logic [COORD_W-1:0] nx, ny;
   logic [COORD_W-1:0] px_src, py_src;
   logic [15:0]        px_half, py_half;

   always_comb begin
      at_xmax = (cx_q == xmax_q);
      nx      = at_xmax ? xmin_q : (cx_q + COORD_W'(1));
      ny      = at_xmax ? (cy_q + COORD_W'(1)) : cy_q;
      // One converter pair serves both the first pixel (from BBOX) and every later step.
      px_src  = (state_q == StBbox) ? xmin_c : nx;
      py_src  = (state_q == StBbox) ? ymin_c : ny;
      px_half = int2half(px_src);
      py_half = int2half(py_src);
   end

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      in_x_d     = in_x_q;
      in_y_d     = in_y_q;
      vh_x_d     = vh_x_q;
      vh_y_d     = vh_y_q;
      xmin_d     = xmin_q;
      xmax_d     = xmax_q;
      ymax_d     = ymax_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      p_x_d      = p_x_q;
      p_y_d      = p_y_q;
      pix_nd_d   = pix_nd_q;
      pix_last_d = pix_last_q;
      tri_done_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (tri_nd) begin
               in_x_d  = '{tv1_x, tv2_x, tv3_x};
               in_y_d  = '{tv1_y, tv2_y, tv3_y};
               state_d = StBbox;
            end
         end

         StBbox: begin
            for (int i = 0; i < 3; i++) begin
               vh_x_d[i] = int2half(in_x_q[i]);
               vh_y_d[i] = int2half(in_y_q[i]);
            end
            xmin_d = xmin_c;
            xmax_d = xmax_clip;
            ymax_d = ymax_clip;
            if (off_screen) begin
               tri_done_d = 1'b1;
               state_d    = StDone;
            end else begin
               cx_d       = xmin_c;
               cy_d       = ymin_c;
               p_x_d      = px_half;
               p_y_d      = py_half;
               pix_nd_d   = 1'b1;
               pix_last_d = (xmin_c == xmax_clip) && (ymin_c == ymax_clip);
               state_d    = StWalk;
            end
         end

         StWalk: begin
            // pix_nd is always high here, so a transfer is just pix_rfd.
            if (pix_rfd) begin
               if (pix_last_q) begin
                  pix_nd_d   = 1'b0;
                  pix_last_d = 1'b0;
                  tri_done_d = 1'b1;
                  state_d    = StDone;
               end else begin
                  cx_d       = nx;
                  cy_d       = ny;
                  p_x_d      = px_half;
                  p_y_d      = py_half;
                  pix_last_d = (nx == xmax_q) && (ny == ymax_q);
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         for (int i = 0; i < 3; i++) begin
            in_x_q[i] <= '0;
            in_y_q[i] <= '0;
            vh_x_q[i] <= 16'h0000;
            vh_y_q[i] <= 16'h0000;
         end
         xmin_q     <= '0;
         xmax_q     <= '0;
         ymax_q     <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         p_x_q      <= 16'h0000;
         p_y_q      <= 16'h0000;
         pix_nd_q   <= 1'b0;
         pix_last_q <= 1'b0;
         tri_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_x_q     <= in_x_d;
         in_y_q     <= in_y_d;
         vh_x_q     <= vh_x_d;
         vh_y_q     <= vh_y_d;
         xmin_q     <= xmin_d;
         xmax_q     <= xmax_d;
         ymax_q     <= ymax_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         p_x_q      <= p_x_d;
         p_y_q      <= p_y_d;
         pix_nd_q   <= pix_nd_d;
         pix_last_q <= pix_last_d;
         tri_done_q <= tri_done_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign tri_rfd  = (state_q == StIdle);
   assign pix_nd   = pix_nd_q;
   assign pix_last = pix_last_q;
   assign tri_done = tri_done_q;
   assign p_x      = p_x_q;
   assign p_y      = p_y_q;
   assign v1_x     = vh_x_q[0];
   assign v2_x     = vh_x_q[1];
   assign v3_x     = vh_x_q[2];
   assign v1_y     = vh_y_q[0];
   assign v2_y     = vh_y_q[1];
   assign v3_y     = vh_y_q[2];

endmodule

// File: tb/tb_tri_pixel_walker.sv
// ---------------------------------------------------------------------------------------------
// tb_tri_pixel_walker
//
// Scoreboard bench for tri_pixel_walker. Each triangle's expected pixel stream is generated
// by a reference model and queued when the triangle is driven; a monitor pops and compares on
// every pixel transfer, checks stall stability and the tri_done pulse.
// Clipping tests run only when BBOX_CLIP_EN is defined.
// ---------------------------------------------------------------------------------------------
module tb_tri_pixel_walker;

   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tri_nd = 1'b0;
   logic          tri_rfd;
   logic [CW-1:0] tv1_x = '0, tv1_y = '0, tv2_x = '0, tv2_y = '0, tv3_x = '0, tv3_y = '0;
   logic          pix_nd;
   logic          pix_rfd = 1'b1;
   logic [15:0]   v1_x, v1_y, v2_x, v2_y, v3_x, v3_y, p_x, p_y;
   logic          pix_last;
   logic          tri_done;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [32:0]   exp_q [$];     // {last, p_x, p_y}
   int            done_cnt   = 0;
   bit            allow_done = 1'b0;
   bit            done_due   = 1'b0;
   bit            stall_prev = 1'b0;
   logic [32:0]   stall_val  = '0;
   bit            rfd_toggle = 1'b0;

   tri_pixel_walker #(
      .COORD_W  (CW),
      .SCREEN_W (640),
      .SCREEN_H (480)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .tri_nd   (tri_nd),
      .tri_rfd  (tri_rfd),
      .tv1_x    (tv1_x),
      .tv1_y    (tv1_y),
      .tv2_x    (tv2_x),
      .tv2_y    (tv2_y),
      .tv3_x    (tv3_x),
      .tv3_y    (tv3_y),
      .pix_nd   (pix_nd),
      .pix_rfd  (pix_rfd),
      .v1_x     (v1_x),
      .v1_y     (v1_y),
      .v2_x     (v2_x),
      .v2_y     (v2_y),
      .v3_x     (v3_x),
      .v3_y     (v3_y),
      .p_x      (p_x),
      .p_y      (p_y),
      .pix_last (pix_last),
      .tri_done (tri_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // Reference conversion: find the exponent by shifting down, mantissa by subtraction.
   function automatic logic [15:0] ref_half(input int n);
      int e;
      int m;
      if (n == 0) return 16'h0000;
      e = 10;
      while ((n >> e) == 0) e--;
      m = (n - (1 << e)) << (10 - e);
      return {1'b0, 5'(e + 15), 10'(m)};
   endfunction

   task automatic push_tri(input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3, output int n);
      int          xmn, xmx, ymn, ymx;
      logic [32:0] w;
      xmn = (x1 < x2) ? x1 : x2;  xmn = (x3 < xmn) ? x3 : xmn;
      xmx = (x1 > x2) ? x1 : x2;  xmx = (x3 > xmx) ? x3 : xmx;
      ymn = (y1 < y2) ? y1 : y2;  ymn = (y3 < ymn) ? y3 : ymn;
      ymx = (y1 > y2) ? y1 : y2;  ymx = (y3 > ymx) ? y3 : ymx;
      n = 0;
`ifdef BBOX_CLIP_EN
      if (xmx > 639) xmx = 639;
      if (ymx > 479) ymx = 479;
      if (xmn > 639 || ymn > 479) return;
`endif
      for (int y = ymn; y <= ymx; y++) begin
         for (int x = xmn; x <= xmx; x++) begin
            w = {(x == xmx) && (y == ymx), ref_half(x), ref_half(y)};
            exp_q.push_back(w);
            n++;
         end
      end
   endtask

   // Downstream ready: constant high, or toggling every cycle while rfd_toggle is set.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         pix_rfd = rfd_toggle ? ~pix_rfd : 1'b1;
      end
   end

   // Monitor: sampled on the falling edge, where pix_nd/pix_rfd show the next edge's transfer.
   always @(negedge clk) begin
      logic [32:0] w;
      if (rst) begin
         stall_prev = 1'b0;
         done_due   = 1'b0;
         allow_done = 1'b0;
      end else begin
         if (done_due) begin
            check_eq("done_pulse", 64'(tri_done), 64'd1);
            check_eq("done_nd_low", 64'(pix_nd), 64'd0);
            done_due = 1'b0;
         end
         if (tri_done) begin
            check_eq("done_allowed", 64'(allow_done), 64'd1);
            allow_done = 1'b0;
            done_cnt++;
         end
         if (stall_prev) begin
            check_eq("stall_hold", 64'({pix_nd, pix_last, p_x, p_y}), 64'({1'b1, stall_val}));
         end
         stall_prev = 1'b0;
         if (pix_nd && pix_rfd) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
               w = exp_q.pop_front();
               check_eq("pixel", 64'({pix_last, p_x, p_y}), 64'(w));
               if (w[32]) begin
                  done_due   = 1'b1;
                  allow_done = 1'b1;
               end
            end
         end else if (pix_nd) begin
            stall_prev = 1'b1;
            stall_val  = {pix_last, p_x, p_y};
         end
      end
   end

   task automatic drive_tri(input int x1, input int y1, input int x2, input int y2,
                            input int x3, input int y3);
      int t;
      t = 0;
      while (!tri_rfd && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("rfd_ready", 64'(tri_rfd), 64'd1);
      tv1_x = CW'(x1); tv1_y = CW'(y1);
      tv2_x = CW'(x2); tv2_y = CW'(y2);
      tv3_x = CW'(x3); tv3_y = CW'(y3);
      tri_nd = 1'b1;
      @(posedge clk);
      #1;
      tri_nd = 1'b0;
      // Later changes must be ignored.
      tv1_x = ~tv1_x; tv1_y = ~tv1_y;
      tv2_x = ~tv2_x; tv2_y = ~tv2_y;
      tv3_x = ~tv3_x; tv3_y = ~tv3_y;
   endtask

   task automatic run_tri(input int x1, input int y1, input int x2, input int y2,
                          input int x3, input int y3, input bit poke);
      int n;
      int t;
      int d0;
      push_tri(x1, y1, x2, y2, x3, y3, n);
      if (n == 0) allow_done = 1'b1;
      d0 = done_cnt;
      drive_tri(x1, y1, x2, y2, x3, y3);
      @(negedge clk);
      check_eq("lat_bbox", 64'(pix_nd), 64'd0);
      check_eq("rfd_busy", 64'(tri_rfd), 64'd0);
      if (n > 0) begin
         @(negedge clk);
         check_eq("lat_first", 64'(pix_nd), 64'd1);
         check_eq("v1_x", 64'(v1_x), 64'(ref_half(x1)));
         check_eq("v1_y", 64'(v1_y), 64'(ref_half(y1)));
         check_eq("v2_x", 64'(v2_x), 64'(ref_half(x2)));
         check_eq("v2_y", 64'(v2_y), 64'(ref_half(y2)));
         check_eq("v3_x", 64'(v3_x), 64'(ref_half(x3)));
         check_eq("v3_y", 64'(v3_y), 64'(ref_half(y3)));
         if (poke) begin
            tv1_x = 11'd5; tv1_y = 11'd5; tv2_x = 11'd6; tv2_y = 11'd5;
            tv3_x = 11'd5; tv3_y = 11'd6;
            tri_nd = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check_eq("rfd_walk", 64'(tri_rfd), 64'd0);
            end
            tri_nd = 1'b0;
         end
      end
      t = 0;
      while (done_cnt == d0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check_eq("done_seen", 64'(done_cnt - d0), 64'd1);
      check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
      if (poke) check_eq("v_hold", 64'(v1_x), 64'(ref_half(x1)));
   endtask

   initial begin
      int n;
      int d0;

      // Reset values
      repeat (2) @(negedge clk);
      check_eq("rst_rfd", 64'(tri_rfd), 64'd1);
      check_eq("rst_nd", 64'(pix_nd), 64'd0);
      check_eq("rst_last", 64'(pix_last), 64'd0);
      check_eq("rst_done", 64'(tri_done), 64'd0);
      check_eq("rst_px", 64'(p_x), 64'd0);
      check_eq("rst_v1x", 64'(v1_x), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 2x2 box
      run_tri(0, 1, 0, 0, 1, 0, 1'b0);
      // 4x2 box with stalls
      rfd_toggle = 1'b1;
      run_tri(2, 3, 5, 3, 2, 4, 1'b0);
      rfd_toggle = 1'b0;
      // Single pixel
      run_tri(7, 7, 7, 7, 7, 7, 1'b0);
      // Max coordinate, tri_nd asserted mid-walk
      run_tri(2047, 0, 2040, 0, 2047, 2, 1'b1);

      // Reset during a 10x10 walk
      push_tri(0, 0, 9, 0, 0, 9, n);
      drive_tri(0, 0, 9, 0, 0, 9);
      repeat (15) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rstw_nd", 64'(pix_nd), 64'd0);
      check_eq("rstw_px", 64'(p_x), 64'd0);
      check_eq("rstw_py", 64'(p_y), 64'd0);
      check_eq("rstw_v2x", 64'(v2_x), 64'd0);
      check_eq("rstw_last", 64'(pix_last), 64'd0);
      check_eq("rstw_rfd", 64'(tri_rfd), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      check_eq("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
      run_tri(3, 4, 5, 4, 3, 5, 1'b0);

`ifdef BBOX_CLIP_EN
      run_tri(630, 0, 700, 0, 630, 1, 1'b0);
      run_tri(700, 5, 710, 5, 700, 6, 1'b0);
`endif

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
